led_scroll_ctrl: RTL

LED_SCROLL_CTRL -- requirements
Module: led_scroll_ctrl

---
 rtl/led_scroll_ctrl_if.sv | 10 +
 rtl/led_scroll_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_scroll_ctrl_if.sv
// Debug view of led_scroll_ctrl internals: FSM state, current owner and the
// debounced button levels, so checkers can bind without reaching into the RTL.
interface led_scroll_ctrl_if;
    logic [1:0] state;
    logic       owner;
    logic [1:0] stable;

    modport master (output state, output owner, output stable);
    modport slave  (input state, input owner, input stable);
endinterface

// File: rtl/led_scroll_ctrl.sv
// Two-button LED scroller: synchronised and debounced buttons, round-robin
// arbitration, one move on press, then auto-repeat after HOLD_STEPS ticks.
module led_scroll_ctrl #(
    parameter int MAIN_CLOCK_FREQ = 12000000,
    parameter int DEBOUNCE_FREQ   = 8,
    parameter int STEP_FREQ       = 4,
    parameter int HOLD_STEPS      = 2
) (
    input  logic              CLK_IN,
    input  logic              RST_IN,
    input  logic              BTN_LEFT_N_i,
    input  logic              BTN_RIGHT_N_i,
    output logic [7:0]        LED_o,
    output logic [1:0]        GRANT_o,
    output logic              STEP_o,
    led_scroll_ctrl_if.master dbg_o
);

    localparam int DB_COUNT   = MAIN_CLOCK_FREQ / DEBOUNCE_FREQ;
    localparam int STEP_COUNT = MAIN_CLOCK_FREQ / STEP_FREQ;
    localparam int DB_W       = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam int ST_W       = (STEP_COUNT > 1) ? $clog2(STEP_COUNT) : 1;

    localparam logic [DB_W-1:0] DB_LOAD   = DB_W'(DB_COUNT - 1);
    localparam logic [ST_W-1:0] ST_LOAD   = ST_W'(STEP_COUNT - 1);
    localparam logic [3:0]      HOLD_LAST = 4'(HOLD_STEPS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    // Bit 1 is the left button, bit 0 the right, matching GRANT_o.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0] req;

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_left_q, last_left_d;
    logic [ST_W-1:0] tick_q, tick_d;
    logic [3:0]      hold_q, hold_d;
    logic [7:0]      led_q, led_d;
    logic            step_q;
    logic            move, move_left, grant_left, owner_req, tick;

    assign btn_raw = {BTN_LEFT_N_i, BTN_RIGHT_N_i};

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Counter sits at DB_LOAD while settled; a disagreement must persist for
    // DB_COUNT consecutive cycles before the stable level follows.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = DB_LOAD;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == '0) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] - DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            stable_q <= 2'b11;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= DB_LOAD;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign req       = ~stable_q;
    assign owner_req = owner_q ? req[1] : req[0];
    assign tick      = (tick_q == '0);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_left_d = last_left_q;
        tick_d      = tick_q;
        hold_d      = hold_q;
        move        = 1'b0;
        move_left   = owner_q;
        grant_left  = req[1] & (~req[0] | ~last_left_q);
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d     = grant_left;
                    last_left_d = grant_left;
                    move        = 1'b1;
                    move_left   = grant_left;
                    tick_d      = ST_LOAD;
                    hold_d      = 4'd0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                // Release wins over a coincident tick, so no move on the way out.
                if (!owner_req) begin
                    state_d = S_IDLE;
                end else begin
                    tick_d = tick ? ST_LOAD : tick_q - ST_W'(1);
                    if (tick) begin
                        if (state_q == S_REPEAT) begin
                            move = 1'b1;
                        end else if (hold_q == HOLD_LAST) begin
                            move    = 1'b1;
                            state_d = S_REPEAT;
                        end else begin
                            hold_d = hold_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        led_d = led_q;
        if (move) begin
            if (move_left) led_d = led_q[7] ? 8'h01 : {led_q[6:0], 1'b0};
            else           led_d = led_q[0] ? 8'h80 : {1'b0, led_q[7:1]};
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_left_q <= 1'b0;
            tick_q      <= ST_LOAD;
            hold_q      <= 4'd0;
            led_q       <= 8'h01;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_left_q <= last_left_d;
            tick_q      <= tick_d;
            hold_q      <= hold_d;
            led_q       <= led_d;
            step_q      <= move;
        end
    end

    assign LED_o   = led_q;
    assign STEP_o  = step_q;
    assign GRANT_o = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

    assign dbg_o.state  = state_q;
    assign dbg_o.owner  = owner_q;
    assign dbg_o.stable = stable_q;

endmodule
